pipe_skid_reg_64: RTL and testbench

PIPE_SKID_REG_64 -- requirements
Module: pipe_skid_reg_64

---
 rtl/pipe_skid_reg_64_if.sv | 36 +++
 rtl/pipe_skid_reg_64.sv | 87 ++++++++
 tb/tb_pipe_skid_reg_64.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_skid_reg_64_if.sv
// Handshake bundle for the two-entry skid register: upstream
// push side, downstream pop side and the held-entry count.
// Ports (slave = register side):
//   in_valid/in_data -> in_ready, out_ready -> out_valid/out_data,
//   occupancy = number of held entries (0..2).
interface pipe_skid_reg_64_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [1:0]       occupancy;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        output out_ready,
        input  occupancy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        input  out_ready,
        output occupancy
    );
endinterface

// File: rtl/pipe_skid_reg_64.sv
// Two-entry skid register between pipeline stages, in-order,
// 1-cycle latency, all handshake outputs registered.
// Ports: clk, Reset (sync, active-high), flush (drop all entries),
//   bus (slave side of pipe_skid_reg_64_if).
module pipe_skid_reg_64 #(
    parameter int WIDTH = 64
) (
    input logic               clk,
    input logic               Reset,
    input logic               flush,
    pipe_skid_reg_64_if.slave bus
);
    // Encoding equals the number of held entries.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [1:0]       r_occ;
    logic             w_accept;
    logic             w_deliver;

    assign w_accept  = bus.in_valid & r_in_ready;
    assign w_deliver = r_out_valid & bus.out_ready;

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_main;
    assign bus.occupancy = r_occ;

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            EMPTY: if (w_accept) w_nxt = ONE;
            ONE: begin
                if (w_accept && !w_deliver)
                    w_nxt = FULL;
                else if (!w_accept && w_deliver)
                    w_nxt = EMPTY;
            end
            FULL: if (w_deliver) w_nxt = ONE;
            default: w_nxt = EMPTY;
        endcase
        if (flush)
            w_nxt = EMPTY;
    end

    // Handshake flags are precomputed from the next state so
    // they never depend combinationally on in_valid/out_ready.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state     <= EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_occ       <= 2'd0;
        end else begin
            r_state     <= w_nxt;
            r_out_valid <= (w_nxt != EMPTY);
            r_in_ready  <= (w_nxt != FULL);
            r_occ       <= w_nxt;
            // A flush cycle writes nothing: the accepted entry
            // is dropped and the old contents are don't-care.
            if (!flush) begin
                unique case (r_state)
                    EMPTY: if (w_accept) r_main <= bus.in_data;
                    ONE: begin
                        if (w_accept && w_deliver)
                            r_main <= bus.in_data;
                        else if (w_accept)
                            r_skid <= bus.in_data;
                    end
                    FULL: if (w_deliver) r_main <= r_skid;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pipe_skid_reg_64.sv
// Directed bench for pipe_skid_reg_64 with a queue scoreboard
// checked every cycle plus directed end-of-scenario checks.
module tb_pipe_skid_reg_64;
    localparam int W = 64;

    logic clk = 1'b0;
    logic Reset;
    logic flush;

    pipe_skid_reg_64_if #(.WIDTH(W)) bus ();

    pipe_skid_reg_64 #(.WIDTH(W)) dut (
        .clk   (clk),
        .Reset (Reset),
        .flush (flush),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] q[$];
    logic [W-1:0] dl[$];

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check outputs against the model, update the model with this
    // cycle's handshakes, then advance one clock.
    task automatic cyc();
        int  mo;
        bit  acc;
        bit  del;
        mo  = q.size();
        chk("in_ready", W'(bus.in_ready), W'(mo != 2));
        chk("out_valid", W'(bus.out_valid), W'(mo != 0));
        chk("occupancy", W'(bus.occupancy), W'(mo));
        if (mo != 0)
            chk("out_data", bus.out_data, q[0]);
        acc = bus.in_valid && (mo < 2);
        del = bus.out_ready && (mo > 0);
        if (Reset) begin
            q.delete();
        end else if (flush) begin
            if (del) dl.push_back(q[0]);
            q.delete();
        end else begin
            if (del) dl.push_back(q.pop_front());
            if (acc) q.push_back(bus.in_data);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nxt;
        int n;
        bit seen;
        Reset         = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        Reset = 1'b0;
        chk("rst_data", bus.out_data, '0);
        chk("rst_valid", W'(bus.out_valid), '0);
        chk("rst_ready", W'(bus.in_ready), W'(1));
        chk("rst_occ", W'(bus.occupancy), '0);

        // Single entry, 1-cycle latency
        bus.in_valid  = 1'b1;
        bus.in_data   = 64'h0000_0000_0040_0000;
        bus.out_ready = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        chk("lat_valid", W'(bus.out_valid), W'(1));
        chk("lat_data", bus.out_data, 64'h40_0000);
        cyc();
        cyc();
        chk("hold_data", bus.out_data, 64'h40_0000);
        chk("drain_occ", W'(bus.occupancy), '0);

        // Fill to FULL, reject third, drain
        dl.delete();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 64'h10;
        cyc();
        bus.in_data = 64'h20;
        cyc();
        chk("full_occ", W'(bus.occupancy), W'(2));
        chk("full_ready", W'(bus.in_ready), '0);
        bus.in_data = 64'h30;
        cyc();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        cyc();
        chk("after1_ready", W'(bus.in_ready), W'(1));
        cyc();
        bus.out_ready = 1'b0;
        cyc();
        chk("full_cnt", W'(dl.size()), W'(2));
        if (dl.size() == 2) begin
            chk("full_d0", dl[0], 64'h10);
            chk("full_d1", dl[1], 64'h20);
        end

        // Stream 1..8 with toggling out_ready
        dl.delete();
        nxt = 1;
        n   = 0;
        bus.out_ready = 1'b1;
        while (dl.size() < 8 && n < 60) begin
            bus.in_valid = (nxt <= 8);
            bus.in_data  = W'(nxt);
            if (bus.in_valid && q.size() < 2) nxt++;
            cyc();
            bus.out_ready = ~bus.out_ready;
            n++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("seq_cnt", W'(dl.size()), W'(8));
        for (int i = 0; i < dl.size() && i < 8; i++)
            chk("seq_data", dl[i], W'(i + 1));
        cyc();

        // Flush while FULL
        dl.delete();
        bus.in_valid = 1'b1;
        bus.in_data  = 64'hA;
        cyc();
        bus.in_data = 64'hB;
        cyc();
        flush       = 1'b1;
        bus.in_data = 64'hC;
        cyc();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl_occ", W'(bus.occupancy), '0);
        chk("fl_valid", W'(bus.out_valid), '0);
        bus.out_ready = 1'b1;
        repeat (3) cyc();
        seen = 1'b0;
        foreach (dl[i]) if (dl[i] == 64'hC) seen = 1'b1;
        chk("fl_noC", W'(seen), '0);

        // Reset while ONE
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 64'h5;
        cyc();
        bus.in_valid = 1'b0;
        cyc();
        Reset         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 64'h99;
        bus.out_ready = 1'b1;
        cyc();
        Reset        = 1'b0;
        bus.in_valid = 1'b0;
        chk("mr_valid", W'(bus.out_valid), '0);
        chk("mr_data", bus.out_data, '0);
        chk("mr_ready", W'(bus.in_ready), W'(1));
        chk("mr_occ", W'(bus.occupancy), '0);
        cyc();

        // Full throughput for 16 cycles
        dl.delete();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.in_data = W'(64'h100 + i);
            cyc();
            chk("tp_occ", W'(bus.occupancy), W'(1));
        end
        chk("tp_cnt", W'(dl.size()), W'(15));
        for (int i = 0; i < dl.size(); i++)
            chk("tp_data", dl[i], W'(64'h100 + i));
        bus.in_valid = 1'b0;
        repeat (2) cyc();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
